// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg : shared ALU opcodes, datapath widths and forwarding helper
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int SW = 6;

  localparam logic [RW-1:0] REG_ZERO = 5'd0;
  localparam logic [RW-1:0] REG_RA   = 5'd31;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_NOR = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110
  } alu_op_e;

  // $0 is hard-wired, so a write to it never supplies a forwarded value.
  function automatic logic is_fwd_match(input logic          regwrite,
                                        input logic [RW-1:0] rd,
                                        input logic [RW-1:0] src);
    return regwrite && (rd != REG_ZERO) && (rd == src);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux : one operand forwarding selector (EX/MEM over MEM/WB over regfile)
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module fwd_mux
  import alu_pkg::*;
#(
  parameter int DW = alu_pkg::DW,
  parameter int RW = alu_pkg::RW
) (
  input  logic [RW-1:0] src_reg,
  input  logic [DW-1:0] src_data,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] fwd_data
);

  // Later assignment wins, so the younger EX/MEM producer takes priority.
  always_comb begin
    fwd_data = src_data;
    if (is_fwd_match(memwb_regwrite, memwb_rd, src_reg)) fwd_data = memwb_result;
    if (is_fwd_match(exmem_regwrite, exmem_rd, src_reg)) fwd_data = exmem_result;
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register, operand forwarding, load-use bubble
// Option      : ID_EX_FORWARD_EN enables forwarding and load-use detection
// Rev 1.0     : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DW = alu_pkg::DW,
  parameter int RW = alu_pkg::RW,
  parameter int SW = alu_pkg::SW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd_dst,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] id_pc4,
  input  logic          id_alusrc,
  input  logic [2:0]    id_alu_control,
  input  logic [SW-1:0] id_shamt,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          id_jal,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_control,
  output logic [SW-1:0] alu_shamt,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd_dst,
  output logic [DW-1:0] ex_pc4,
  output logic          ex_valid,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_jal,
  output logic          load_use_stall
);

  logic [RW-1:0] ex_rs;
  logic [RW-1:0] ex_rt;
  logic [DW-1:0] ex_rs_data;
  logic [DW-1:0] ex_rt_data;
  logic [DW-1:0] ex_imm;
  logic          ex_alusrc;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic          exmem_we;
  logic          memwb_we;

`ifdef ID_EX_FORWARD_EN
  assign exmem_we = exmem_regwrite;
  assign memwb_we = memwb_regwrite;
  assign load_use_stall = ex_valid && ex_memread && (ex_rd_dst != REG_ZERO) && id_valid &&
                          ((ex_rd_dst == id_rs) || (ex_rd_dst == id_rt));
`else
  // Without forwarding the selectors never match; software schedules nops.
  logic unused_fwd;
  assign exmem_we       = 1'b0;
  assign memwb_we       = 1'b0;
  assign load_use_stall = 1'b0;
  assign unused_fwd     = exmem_regwrite ^ memwb_regwrite;
`endif

  always_ff @(posedge clk) begin
    if (reset || (!stall && (flush || load_use_stall))) begin
      ex_valid    <= 1'b0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd_dst   <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_pc4      <= '0;
      ex_alusrc   <= 1'b0;
      alu_control <= ALU_AND;
      alu_shamt   <= '0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_jal      <= 1'b0;
    end else if (!stall) begin
      ex_valid    <= id_valid;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd_dst   <= id_rd_dst;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      ex_pc4      <= id_pc4;
      ex_alusrc   <= id_alusrc;
      alu_control <= id_alu_control;
      alu_shamt   <= id_shamt;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_memtoreg <= id_memtoreg;
      ex_jal      <= id_jal;
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_reg        (ex_rs),
    .src_data       (ex_rs_data),
    .exmem_regwrite (exmem_we),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_we),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .fwd_data       (fwd_rs)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_reg        (ex_rt),
    .src_data       (ex_rt_data),
    .exmem_regwrite (exmem_we),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_we),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .fwd_data       (fwd_rt)
  );

  // Stores always need the forwarded rt, even when the ALU takes the immediate.
  assign alu_a         = fwd_rs;
  assign alu_b         = ex_alusrc ? ex_imm : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage : directed scenarios plus randomized run against a stage model
// Rev 1.0        : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;
  import alu_pkg::*;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic        clk, reset, stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd_dst;
  logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic        id_alusrc;
  logic [2:0]  id_alu_control;
  logic [5:0]  id_shamt;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_jal;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc4;
  logic [2:0]  alu_control;
  logic [5:0]  alu_shamt;
  logic [4:0]  ex_rd_dst;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_jal;
  logic        load_use_stall;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd_dst(id_rd_dst),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_alusrc(id_alusrc), .id_alu_control(id_alu_control), .id_shamt(id_shamt),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_jal(id_jal),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_shamt(alu_shamt),
    .ex_store_data(ex_store_data), .ex_rd_dst(ex_rd_dst), .ex_pc4(ex_pc4),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_jal(ex_jal),
    .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference view of the instruction currently sitting in EX.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm, pc4;
    logic        alusrc;
    logic [2:0]  ctl;
    logic [5:0]  shamt;
    logic        regwrite, memread, memwrite, memtoreg, jal;
  } stage_t;

  stage_t m = '0;

  // Newest in-flight producer of a non-zero register supplies the operand.
  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] d);
    if (FWD_EN && exmem_regwrite && r != 5'd0 && exmem_rd == r) return exmem_result;
    if (FWD_EN && memwb_regwrite && r != 5'd0 && memwb_rd == r) return memwb_result;
    return d;
  endfunction

  function automatic logic m_lus();
    return FWD_EN && m.valid && m.memread && m.rd != 5'd0 && id_valid &&
           (m.rd == id_rs || m.rd == id_rt);
  endfunction

  task automatic tick();
    stage_t n;
    if (reset)                   n = '0;
    else if (stall)              n = m;
    else if (flush || m_lus())   n = '0;
    else begin
      n.valid = id_valid;     n.rs = id_rs;           n.rt = id_rt;
      n.rd = id_rd_dst;       n.rs_data = id_rs_data; n.rt_data = id_rt_data;
      n.imm = id_imm;         n.pc4 = id_pc4;         n.alusrc = id_alusrc;
      n.ctl = id_alu_control; n.shamt = id_shamt;     n.regwrite = id_regwrite;
      n.memread = id_memread; n.memwrite = id_memwrite;
      n.memtoreg = id_memtoreg; n.jal = id_jal;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [2:0] ctl);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd_dst = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_alu_control = ctl;
    id_imm = 32'h0; id_pc4 = 32'h0; id_alusrc = 1'b0; id_shamt = 6'd0;
    id_regwrite = 1'b1; id_memread = 1'b0; id_memwrite = 1'b0;
    id_memtoreg = 1'b0; id_jal = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;
    set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 3'b010);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({ex_valid, alu_a, alu_b, alu_control, ex_regwrite, ex_rd_dst, load_use_stall} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got valid=%b a=%h b=%h ctl=%b lus=%b, required all 0",
                 i, ex_valid, alu_a, alu_b, alu_control, load_use_stall);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (alu_a !== 32'd5) begin errors++; $display("FAIL first_alu_a: got %0d required 5", alu_a); end
    checks++;
    if (alu_b !== 32'd7) begin errors++; $display("FAIL first_alu_b: got %0d required 7", alu_b); end
    checks++;
    if ({ex_valid, alu_control} !== 4'b1_010) begin
      errors++; $display("FAIL first_ctl: got valid=%b ctl=%b required valid=1 ctl=010", ex_valid, alu_control);
    end
  endtask

  task automatic test_forward();
    exmem_regwrite = 1'b1; exmem_rd = 5'd1; exmem_result = 32'd100;
    memwb_regwrite = 1'b1; memwb_rd = 5'd1; memwb_result = 32'd200;
    #1;
    checks++;
    if (alu_a !== (FWD_EN ? 32'd100 : 32'd5)) begin
      errors++; $display("FAIL fwd_exmem_priority: got %0d required %0d", alu_a, FWD_EN ? 100 : 5);
    end
    exmem_regwrite = 1'b0; memwb_rd = 5'd2;
    #1;
    checks++;
    if ({alu_a, ex_store_data} !== {32'd5, (FWD_EN ? 32'd200 : 32'd7)}) begin
      errors++; $display("FAIL fwd_memwb_rt: got a=%0d sd=%0d required a=5 sd=%0d",
                         alu_a, ex_store_data, FWD_EN ? 200 : 7);
    end
    memwb_regwrite = 1'b0;
  endtask

  task automatic test_reg_zero();
    set_id(5'd0, 5'd0, 5'd4, 32'd0, 32'd9, 3'b010);
    tick();
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'd55;
    memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_result = 32'd66;
    #1;
    checks++;
    if ({alu_a, ex_store_data} !== {32'd0, 32'd9}) begin
      errors++; $display("FAIL reg_zero_nofwd: got a=%0d sd=%0d required a=0 sd=9", alu_a, ex_store_data);
    end
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
  endtask

  task automatic test_load_use();
    set_id(5'd1, 5'd0, 5'd3, 32'h10, 32'h0, 3'b010);
    id_imm = 32'd4; id_alusrc = 1'b1; id_memread = 1'b1; id_memtoreg = 1'b1;
    tick();
    set_id(5'd4, 5'd3, 5'd5, 32'h44, 32'h33, 3'b010);
    #1;
    checks++;
    if (load_use_stall !== FWD_EN) begin
      errors++; $display("FAIL load_use_detect: got %b required %b", load_use_stall, FWD_EN);
    end
    tick();
    checks++;
    if ({ex_valid, load_use_stall} !== {!FWD_EN, 1'b0}) begin
      errors++; $display("FAIL load_use_bubble: got valid=%b lus=%b required valid=%b lus=0",
                         ex_valid, load_use_stall, !FWD_EN);
    end
    tick();
    checks++;
    if ({ex_valid, ex_rd_dst, load_use_stall} !== {1'b1, 5'd5, 1'b0}) begin
      errors++; $display("FAIL load_use_capture: got valid=%b rd=%0d lus=%b required valid=1 rd=5 lus=0",
                         ex_valid, ex_rd_dst, load_use_stall);
    end
  endtask

  task automatic test_stall_flush();
    set_id(5'd6, 5'd7, 5'd7, 32'hAA, 32'hBB, 3'b001);
    stall = 1'b1; flush = 1'b1;
    tick();
    checks++;
    if ({ex_valid, ex_rd_dst, alu_a, alu_control} !== {1'b1, 5'd5, 32'h44, 3'b010}) begin
      errors++; $display("FAIL stall_over_flush: got valid=%b rd=%0d a=%h ctl=%b required 1/5/44/010",
                         ex_valid, ex_rd_dst, alu_a, alu_control);
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({ex_valid, ex_regwrite} !== 2'b00) begin
      errors++; $display("FAIL flush_bubble: got valid=%b rw=%b required 0/0", ex_valid, ex_regwrite);
    end
    flush = 1'b0;
  endtask

  task automatic test_shift();
    set_id(5'd0, 5'd2, 5'd8, 32'h0, 32'h1, 3'b100);
    id_shamt = 6'd4; id_imm = 32'hFFFF;
    tick();
    checks++;
    if ({alu_shamt, alu_b, alu_control} !== {6'd4, 32'd1, 3'b100}) begin
      errors++; $display("FAIL sll_operands: got shamt=%0d b=%h ctl=%b required 4/1/100",
                         alu_shamt, alu_b, alu_control);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_id(5'd1, 5'd0, 5'd3, 32'h0, 32'h0, 3'b010);
    id_memread = 1'b1;
    tick();
    set_id(5'd3, 5'd0, 5'd9, 32'h0, 32'h0, 3'b010);
    #1;
    checks++;
    if (load_use_stall !== FWD_EN) begin
      errors++; $display("FAIL mid_stall_detect: got %b required %b", load_use_stall, FWD_EN);
    end
    reset = 1'b1; stall = 1'b1;
    tick();
    checks++;
    if ({ex_valid, ex_memread, load_use_stall} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_stall: got valid=%b mr=%b lus=%b required 0/0/0",
                         ex_valid, ex_memread, load_use_stall);
    end
    reset = 1'b0; stall = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_rt;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      id_valid = $urandom_range(0, 3) != 0;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd_dst = 5'($urandom_range(0, 3));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; id_pc4 = $urandom;
      id_alusrc = 1'($urandom); id_alu_control = 3'($urandom); id_shamt = 6'($urandom);
      id_regwrite = 1'($urandom); id_memread = 1'($urandom); id_memwrite = 1'($urandom);
      id_memtoreg = 1'($urandom); id_jal = 1'($urandom);
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      #1;
      exp_rt = m_fwd(m.rt, m.rt_data);
      checks++;
      if ({alu_a, alu_b, ex_store_data, alu_control, alu_shamt, ex_rd_dst, ex_pc4, ex_valid,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_jal, load_use_stall} !==
          {m_fwd(m.rs, m.rs_data), (m.alusrc ? m.imm : exp_rt), exp_rt, m.ctl, m.shamt, m.rd,
           m.pc4, m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg, m.jal, m_lus()}) begin
        errors++;
        $display("FAIL random[%0d]: got a=%h b=%h sd=%h ctl=%b sh=%0d rd=%0d pc4=%h v/rw/mr/mw/mt/j/lus=%b%b%b%b%b%b%b required a=%h b=%h sd=%h ctl=%b sh=%0d rd=%0d pc4=%h v/rw/mr/mw/mt/j/lus=%b%b%b%b%b%b%b",
                 i, alu_a, alu_b, ex_store_data, alu_control, alu_shamt, ex_rd_dst, ex_pc4,
                 ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_jal, load_use_stall,
                 m_fwd(m.rs, m.rs_data), (m.alusrc ? m.imm : exp_rt), exp_rt, m.ctl, m.shamt, m.rd,
                 m.pc4, m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg, m.jal, m_lus());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reg_zero();
    test_load_use();
    test_stall_flush();
    test_shift();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
